// File: rtl/amo_sequencer_pkg.sv
// Shared encodings for the atomic sequencer: AMO opcodes (RV32A funct5),
// the ALU function select it drives, and the FSM state type.
package amo_sequencer_pkg;

   localparam int AMO_OP_WIDTH = 5;
   localparam int ALU_OP_WIDTH = 4;

   localparam logic [AMO_OP_WIDTH-1:0] AMO_OP_ADD  = 5'b00000;
   localparam logic [AMO_OP_WIDTH-1:0] AMO_OP_SWAP = 5'b00001;
   localparam logic [AMO_OP_WIDTH-1:0] AMO_OP_LR   = 5'b00010;
   localparam logic [AMO_OP_WIDTH-1:0] AMO_OP_SC   = 5'b00011;
   localparam logic [AMO_OP_WIDTH-1:0] AMO_OP_XOR  = 5'b00100;
   localparam logic [AMO_OP_WIDTH-1:0] AMO_OP_OR   = 5'b01000;
   localparam logic [AMO_OP_WIDTH-1:0] AMO_OP_AND  = 5'b01100;
   localparam logic [AMO_OP_WIDTH-1:0] AMO_OP_MIN  = 5'b10000;
   localparam logic [AMO_OP_WIDTH-1:0] AMO_OP_MAX  = 5'b10100;
   localparam logic [AMO_OP_WIDTH-1:0] AMO_OP_MINU = 5'b11000;
   localparam logic [AMO_OP_WIDTH-1:0] AMO_OP_MAXU = 5'b11100;

   // The ALU decoder sees this value and picks its function from AMOop.
   localparam logic [ALU_OP_WIDTH-1:0] ALU_OP_AMO = 4'b1010;

   typedef enum logic [2:0] {
      AMO_SEQ_S_IDLE    = 3'd0,
      AMO_SEQ_S_LOAD    = 3'd1,
      AMO_SEQ_S_COMPUTE = 3'd2,
      AMO_SEQ_S_STORE   = 3'd3,
      AMO_SEQ_S_DONE    = 3'd4
   } amo_seq_state_e;

   function automatic logic amo_op_known(input logic [AMO_OP_WIDTH-1:0] op);
      case (op)
         AMO_OP_ADD, AMO_OP_SWAP, AMO_OP_LR, AMO_OP_SC, AMO_OP_XOR, AMO_OP_OR,
         AMO_OP_AND, AMO_OP_MIN, AMO_OP_MAX, AMO_OP_MINU, AMO_OP_MAXU: return 1'b1;
         default: return 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/amo_reservation.sv
// LR/SC reservation: one word address plus a valid bit.
// Optional macro AMO_RESV_TIMEOUT_EN adds a lifetime counter that drops the
// reservation RESV_TIMEOUT cycles after the LR that set it.
module amo_reservation #(
   parameter int XLEN         = 32,
   parameter int RESV_TIMEOUT = 1024
) (
   input  logic            clk_i,
   input  logic            reset_i,
   input  logic            set_i,
   input  logic [XLEN-3:0] set_addr_i,
   input  logic            sc_clr_i,
   input  logic            store_clr_i,
   input  logic [XLEN-3:0] store_addr_i,
   input  logic            snoop_store_i,
   input  logic [XLEN-3:0] snoop_addr_i,
   input  logic [XLEN-3:0] query_addr_i,
   output logic            resv_hit_o
);

   logic            valid_q, valid_d;
   logic [XLEN-3:0] addr_q, addr_d;
   logic            expire;
   logic            snoop_hit;

`ifdef AMO_RESV_TIMEOUT_EN
   localparam int CNT_W = (RESV_TIMEOUT > 1) ? $clog2(RESV_TIMEOUT) : 1;
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(RESV_TIMEOUT - 1);

   logic [CNT_W-1:0] cnt_q, cnt_d;

   // Lifetime counter: reload on LR, run down while the reservation lives.
   always_comb begin
      cnt_d = cnt_q;
      if (set_i) begin
         cnt_d = CNT_LOAD;
      end else if (valid_q && (cnt_q != '0)) begin
         cnt_d = cnt_q - CNT_W'(1);
      end
   end

   // Counter register.
   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) cnt_q <= '0;
      else         cnt_q <= cnt_d;
   end

   assign expire = valid_q && (cnt_q == '0) && !set_i;
`else
   logic unused_timeout;
   assign unused_timeout = ^RESV_TIMEOUT;
   assign expire         = 1'b0;
`endif

   // A snoop landing this cycle already counts against an SC decided now.
   assign snoop_hit  = snoop_store_i && (snoop_addr_i == addr_q);
   assign resv_hit_o = valid_q && !snoop_hit && (addr_q == query_addr_i);

   // Set first, then let every clear source override against the new address.
   always_comb begin
      valid_d = valid_q;
      addr_d  = addr_q;
      if (set_i) begin
         valid_d = 1'b1;
         addr_d  = set_addr_i;
      end
      if (sc_clr_i || expire)                              valid_d = 1'b0;
      if (store_clr_i && (store_addr_i == addr_d))         valid_d = 1'b0;
      if (snoop_store_i && (snoop_addr_i == addr_d))       valid_d = 1'b0;
   end

   // Reservation register.
   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         valid_q <= 1'b0;
         addr_q  <= '0;
      end else begin
         valid_q <= valid_d;
         addr_q  <= addr_d;
      end
   end

endmodule

// File: rtl/amo_sequencer.sv
// Read-modify-write sequencer for RV32A atomics on the shared memory port.
// Optional macro AMO_RESV_TIMEOUT_EN enables the reservation lifetime counter.
//
//   state   | meaning
//   IDLE    | wait for start; decide abort / SC outcome / load
//   LOAD    | read request held until mem_ready
//   COMPUTE | register store data (rs2 or ALU result)
//   STORE   | write request held until mem_ready
//   DONE    | one-cycle done pulse
module amo_sequencer
   import amo_sequencer_pkg::*;
#(
   parameter int XLEN         = 32,
   parameter int RESV_TIMEOUT = 1024
) (
   input  logic                    clk_i,
   input  logic                    reset_i,
   input  logic                    start_i,
   input  logic [AMO_OP_WIDTH-1:0] amo_op_i,
   input  logic [XLEN-1:0]         addr_i,
   input  logic [XLEN-1:0]         rs2_data_i,
   output logic                    mem_valid_o,
   output logic [3:0]              mem_wstrb_o,
   output logic [XLEN-1:0]         mem_addr_o,
   output logic [XLEN-1:0]         mem_wdata_o,
   input  logic [XLEN-1:0]         mem_rdata_i,
   input  logic                    mem_ready_i,
   output logic [ALU_OP_WIDTH-1:0] alu_op_o,
   output logic [XLEN-1:0]         alu_a_o,
   output logic [XLEN-1:0]         alu_b_o,
   input  logic [XLEN-1:0]         alu_result_i,
   input  logic                    snoop_store_i,
   input  logic [XLEN-1:0]         snoop_addr_i,
   output logic [XLEN-1:0]         rd_value_o,
   output logic                    done_o,
   output logic                    misaligned_o
);

   amo_seq_state_e          state_q, state_d;
   logic [AMO_OP_WIDTH-1:0] op_q, op_d;
   logic [XLEN-1:0]         addr_q, addr_d;
   logic [XLEN-1:0]         rs2_q, rs2_d;
   logic [XLEN-1:0]         loaded_q, loaded_d;
   logic [XLEN-1:0]         wdata_q, wdata_d;
   logic [XLEN-1:0]         rd_q, rd_d;
   logic                    mis_q, mis_d;
   logic                    resv_set, sc_clr, store_clr, resv_hit;
   logic [1:0]              unused_snoop_lsb;

   assign unused_snoop_lsb = snoop_addr_i[1:0];

   amo_reservation #(
      .XLEN         (XLEN),
      .RESV_TIMEOUT (RESV_TIMEOUT)
   ) u_resv (
      .clk_i         (clk_i),
      .reset_i       (reset_i),
      .set_i         (resv_set),
      .set_addr_i    (addr_q[XLEN-1:2]),
      .sc_clr_i      (sc_clr),
      .store_clr_i   (store_clr),
      .store_addr_i  (addr_q[XLEN-1:2]),
      .snoop_store_i (snoop_store_i),
      .snoop_addr_i  (snoop_addr_i[XLEN-1:2]),
      .query_addr_i  (addr_i[XLEN-1:2]),
      .resv_hit_o    (resv_hit)
   );

   // Next-state and datapath register updates.
   always_comb begin
      state_d   = state_q;
      op_d      = op_q;
      addr_d    = addr_q;
      rs2_d     = rs2_q;
      loaded_d  = loaded_q;
      wdata_d   = wdata_q;
      rd_d      = rd_q;
      mis_d     = mis_q;
      resv_set  = 1'b0;
      sc_clr    = 1'b0;
      store_clr = 1'b0;
      case (state_q)
         AMO_SEQ_S_IDLE: begin
            if (start_i) begin
               op_d   = amo_op_i;
               addr_d = addr_i;
               rs2_d  = rs2_data_i;
               mis_d  = 1'b0;
               rd_d   = '0;
               // Every SC consumes the reservation, whatever its outcome.
               if (amo_op_i == AMO_OP_SC) sc_clr = 1'b1;
               if (addr_i[1:0] != 2'b00) begin
                  mis_d   = 1'b1;
                  state_d = AMO_SEQ_S_DONE;
               end else if (!amo_op_known(amo_op_i)) begin
                  state_d = AMO_SEQ_S_DONE;
               end else if (amo_op_i == AMO_OP_SC) begin
                  if (resv_hit) begin
                     wdata_d = rs2_data_i;
                     state_d = AMO_SEQ_S_STORE;
                  end else begin
                     rd_d    = XLEN'(1);
                     state_d = AMO_SEQ_S_DONE;
                  end
               end else begin
                  state_d = AMO_SEQ_S_LOAD;
               end
            end
         end
         AMO_SEQ_S_LOAD: begin
            if (mem_ready_i) begin
               loaded_d = mem_rdata_i;
               rd_d     = mem_rdata_i;
               if (op_q == AMO_OP_LR) begin
                  resv_set = 1'b1;
                  state_d  = AMO_SEQ_S_DONE;
               end else begin
                  state_d  = AMO_SEQ_S_COMPUTE;
               end
            end
         end
         AMO_SEQ_S_COMPUTE: begin
            wdata_d = (op_q == AMO_OP_SWAP) ? rs2_q : alu_result_i;
            state_d = AMO_SEQ_S_STORE;
         end
         AMO_SEQ_S_STORE: begin
            if (mem_ready_i) begin
               if (op_q == AMO_OP_SC) rd_d = '0;
               else                   store_clr = 1'b1;
               state_d = AMO_SEQ_S_DONE;
            end
         end
         AMO_SEQ_S_DONE: state_d = AMO_SEQ_S_IDLE;
         default:        state_d = AMO_SEQ_S_IDLE;
      endcase
   end

   // State and datapath registers.
   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         state_q  <= AMO_SEQ_S_IDLE;
         op_q     <= '0;
         addr_q   <= '0;
         rs2_q    <= '0;
         loaded_q <= '0;
         wdata_q  <= '0;
         rd_q     <= '0;
         mis_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         op_q     <= op_d;
         addr_q   <= addr_d;
         rs2_q    <= rs2_d;
         loaded_q <= loaded_d;
         wdata_q  <= wdata_d;
         rd_q     <= rd_d;
         mis_q    <= mis_d;
      end
   end

   // Outputs decode straight from state so reset drops mem_valid at once.
   assign mem_valid_o  = (state_q == AMO_SEQ_S_LOAD) || (state_q == AMO_SEQ_S_STORE);
   assign mem_wstrb_o  = (state_q == AMO_SEQ_S_STORE) ? 4'b1111 : 4'b0000;
   assign mem_addr_o   = addr_q;
   assign mem_wdata_o  = wdata_q;
   assign alu_op_o     = ALU_OP_AMO;
   assign alu_a_o      = loaded_q;
   assign alu_b_o      = rs2_q;
   assign rd_value_o   = rd_q;
   assign done_o       = (state_q == AMO_SEQ_S_DONE);
   assign misaligned_o = (state_q == AMO_SEQ_S_DONE) && mis_q;

endmodule

// File: tb/tb_amo_sequencer.sv
// Bench for amo_sequencer: memory/ALU environment, operation-level model,
// per-cycle compare process and directed scenarios followed by random traffic.
module tb_amo_sequencer;
   import amo_sequencer_pkg::*;

   localparam int RT = 8;

   logic        clk = 1'b0, reset = 1'b1, start = 1'b0;
   logic [4:0]  amo_op = '0;
   logic [31:0] addr = '0, rs2 = '0;
   logic        mem_valid;
   logic [3:0]  mem_wstrb;
   logic [31:0] mem_addr, mem_wdata;
   logic [31:0] mem_rdata = '0;
   logic        mem_ready = 1'b0;
   logic [ALU_OP_WIDTH-1:0] alu_op;
   logic [31:0] alu_a, alu_b, alu_result;
   logic        snoop = 1'b0;
   logic [31:0] snoop_addr = '0;
   logic [31:0] rd_value;
   logic        done, misaligned;

   always #5 clk = ~clk;

   amo_sequencer #(.XLEN(32), .RESV_TIMEOUT(RT)) dut (
      .clk_i(clk), .reset_i(reset), .start_i(start), .amo_op_i(amo_op),
      .addr_i(addr), .rs2_data_i(rs2), .mem_valid_o(mem_valid),
      .mem_wstrb_o(mem_wstrb), .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata),
      .mem_rdata_i(mem_rdata), .mem_ready_i(mem_ready), .alu_op_o(alu_op),
      .alu_a_o(alu_a), .alu_b_o(alu_b), .alu_result_i(alu_result),
      .snoop_store_i(snoop), .snoop_addr_i(snoop_addr), .rd_value_o(rd_value),
      .done_o(done), .misaligned_o(misaligned)
   );

   int tests = 0, fails = 0;
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // ALU environment
   logic [4:0] cur_op = '0;
   function automatic logic [31:0] alu_fn(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
      case (op)
         5'b00000: return a + b;
         5'b00001: return b;
         5'b00100: return a ^ b;
         5'b01000: return a | b;
         5'b01100: return a & b;
         5'b10000: return ($signed(a) < $signed(b)) ? a : b;
         5'b10100: return ($signed(a) > $signed(b)) ? a : b;
         5'b11000: return (a < b) ? a : b;
         5'b11100: return (a > b) ? a : b;
         default:  return 32'h0;
      endcase
   endfunction
   assign alu_result = alu_fn(cur_op, alu_a, alu_b);

   // memory environment
   logic [31:0] mem [int];
   function automatic logic [31:0] mem_rd(input logic [31:0] a);
      int i = int'(a[31:2]);
      if (mem.exists(i)) return mem[i];
      return {a[15:0], ~a[15:0]};
   endfunction
   task automatic mem_wr(input logic [31:0] a, input logic [31:0] d);
      mem[int'(a[31:2])] = d;
   endtask

   typedef struct packed { logic we; logic [31:0] a; logic [31:0] d; } acc_t;
   acc_t acc_q[$];
   acc_t exp_acc[$];
   int   wait_l = 0, wait_s = 0;

   // responder: ready after the configured number of wait cycles, spurious ready when idle
   initial begin
      int wcnt = 0;
      forever begin
         @(negedge clk); #1;
         mem_ready = 1'b0;
         if (reset || !mem_valid) begin
            wcnt = 0;
            if (!reset && ($urandom_range(0, 3) == 0)) mem_ready = 1'b1;
         end else if (wcnt == ((mem_wstrb == 4'hF) ? wait_s : wait_l)) begin
            mem_ready = 1'b1;
            wcnt = 0;
            if (mem_wstrb == 4'hF) begin
               mem_wr(mem_addr, mem_wdata);
               acc_q.push_back({1'b1, mem_addr, mem_wdata});
            end else begin
               mem_rdata = mem_rd(mem_addr);
               acc_q.push_back({1'b0, mem_addr, mem_rdata});
            end
         end else begin
            wcnt++;
         end
      end
   end

   // expectation for the operation in flight
   logic [31:0] exp_rd = '0, last_rd = '0;
   logic        exp_mis = 1'b0;
   int          exp_lat = 0, start_cyc = 0, got_lat = 0;
   bit          busy = 0, got_done = 0;

   // compare process
   initial begin
      logic lv = 0, prev_done = 0;
      logic [31:0] la = '0, ld = '0, prev_rd = '0;
      logic [3:0]  lw = '0;
      forever begin
         @(negedge clk);
         if (reset) begin
            lv = 0; prev_done = 0;
         end else begin
            if (lv && !mem_ready) begin
               chk("hold_valid", {31'b0, mem_valid}, 32'd1);
               chk("hold_addr", mem_addr, la);
               chk("hold_wstrb", {28'b0, mem_wstrb}, {28'b0, lw});
               chk("hold_wdata", mem_wdata, ld);
            end
            if (prev_done) chk("rd_hold", rd_value, prev_rd);
            if (done) begin
               chk("done_expected", {31'b0, busy}, 32'd1);
               if (busy) begin
                  got_lat = cyc - start_cyc;
                  chk("rd_value", rd_value, exp_rd);
                  chk("misaligned", {31'b0, misaligned}, {31'b0, exp_mis});
                  chk("latency", got_lat, exp_lat);
                  chk("acc_count", acc_q.size(), exp_acc.size());
                  for (int i = 0; i < acc_q.size() && i < exp_acc.size(); i++) begin
                     chk("acc_we", {31'b0, acc_q[i].we}, {31'b0, exp_acc[i].we});
                     chk("acc_addr", acc_q[i].a, exp_acc[i].a);
                     chk("acc_data", acc_q[i].d, exp_acc[i].d);
                  end
                  acc_q.delete();
                  busy = 0;
                  got_done = 1;
               end
            end
            lv = mem_valid; la = mem_addr; lw = mem_wstrb; ld = mem_wdata;
            prev_done = done; prev_rd = rd_value;
         end
      end
   end

   // reservation model
   bit          m_rv = 0;
   logic [29:0] m_ra = '0;
   int          m_set = 0;

   function automatic bit legal_op(input logic [4:0] op);
      return op inside {5'b00000, 5'b00001, 5'b00010, 5'b00011, 5'b00100, 5'b01000,
                        5'b01100, 5'b10000, 5'b10100, 5'b11000, 5'b11100};
   endfunction

   task automatic run_op(input logic [4:0] op, input logic [31:0] a, input logic [31:0] d,
                         input int wl, input int ws, input bit snp, input logic [31:0] sa);
      logic [31:0] old;
      bit hit;
      @(negedge clk);
      chk("rd_before_start", rd_value, last_rd);
      start_cyc = cyc;
`ifdef AMO_RESV_TIMEOUT_EN
      if (m_rv && ((start_cyc + 1 - m_set) > RT)) m_rv = 0;
`endif
      if (snp && m_rv && (sa[31:2] == m_ra)) m_rv = 0;
      exp_acc.delete();
      exp_mis = 0;
      if (a[1:0] != 2'b00) begin
         exp_mis = 1; exp_rd = 0; exp_lat = 1;
         if (op == AMO_OP_SC) m_rv = 0;
      end else if (!legal_op(op)) begin
         exp_rd = 0; exp_lat = 1;
      end else if (op == AMO_OP_SC) begin
         hit = m_rv && (m_ra == a[31:2]);
         m_rv = 0;
         if (hit) begin
            exp_acc.push_back({1'b1, a, d});
            exp_rd = 0; exp_lat = 2 + ws;
         end else begin
            exp_rd = 1; exp_lat = 1;
         end
      end else begin
         old = mem_rd(a);
         exp_rd = old;
         exp_acc.push_back({1'b0, a, old});
         if (op == AMO_OP_LR) begin
            exp_lat = 2 + wl;
            m_rv = 1; m_ra = a[31:2]; m_set = start_cyc + exp_lat;
         end else begin
            exp_acc.push_back({1'b1, a, alu_fn(op, old, d)});
            exp_lat = 4 + wl + ws;
            if (m_rv && (m_ra == a[31:2])) m_rv = 0;
         end
      end
      start = 1; amo_op = op; addr = a; rs2 = d; snoop = snp; snoop_addr = sa;
      cur_op = op; wait_l = wl; wait_s = ws; busy = 1; got_done = 0;
      @(negedge clk);
      start = 0; snoop = 0; amo_op = 5'($urandom); addr = $urandom; rs2 = $urandom;
      #2;
      for (int i = 0; i < 200 && !got_done; i++) begin
         @(negedge clk); #2;
      end
      chk("done_seen", {31'b0, got_done}, 32'd1);
      busy = 0;
      last_rd = exp_rd;
   endtask

   task automatic snoop_idle(input logic [31:0] sa);
      @(negedge clk);
      snoop = 1; snoop_addr = sa;
      if (m_rv && (sa[31:2] == m_ra)) m_rv = 0;
      @(negedge clk);
      snoop = 0;
   endtask

   logic [31:0] bases [4] = '{32'h100, 32'h104, 32'h200, 32'h204};
   logic [4:0]  ops [12] = '{5'b00000, 5'b00001, 5'b00010, 5'b00011, 5'b00100, 5'b01000,
                             5'b01100, 5'b10000, 5'b10100, 5'b11000, 5'b11100, 5'b11111};

   initial begin
      logic [31:0] a, old;
      logic [4:0]  op;
      logic [31:0] lr_a = 32'h100;
      // reset state
      repeat (3) @(negedge clk);
      chk("rst_mem_valid", {31'b0, mem_valid}, 32'd0);
      chk("rst_wstrb", {28'b0, mem_wstrb}, 32'd0);
      chk("rst_addr", mem_addr, 32'd0);
      chk("rst_wdata", mem_wdata, 32'd0);
      chk("rst_alu_a", alu_a, 32'd0);
      chk("rst_alu_b", alu_b, 32'd0);
      chk("rst_rd", rd_value, 32'd0);
      chk("rst_done", {31'b0, done}, 32'd0);
      chk("rst_mis", {31'b0, misaligned}, 32'd0);
      chk("rst_alu_op", {28'b0, alu_op}, {28'b0, ALU_OP_AMO});
      reset = 0;

      // AMOADD: 5 + 3
      mem_wr(32'h100, 32'd5);
      run_op(AMO_OP_ADD, 32'h100, 32'd3, 0, 0, 0, 0);
      chk("add_rd", rd_value, 32'd5);
      chk("add_mem", mem_rd(32'h100), 32'd8);
      chk("add_lat", got_lat, 32'd4);

      // LR / SC success / SC again fails
      run_op(AMO_OP_LR, 32'h200, 32'd0, 0, 0, 0, 0);
      chk("lr_lat", got_lat, 32'd2);
      run_op(AMO_OP_SC, 32'h200, 32'hAA, 0, 0, 0, 0);
      chk("sc_ok_rd", rd_value, 32'd0);
      chk("sc_ok_mem", mem_rd(32'h200), 32'hAA);
      chk("sc_ok_lat", got_lat, 32'd2);
      run_op(AMO_OP_SC, 32'h200, 32'hBB, 0, 0, 0, 0);
      chk("sc_again_rd", rd_value, 32'd1);
      chk("sc_again_mem", mem_rd(32'h200), 32'hAA);
      chk("sc_fail_lat", got_lat, 32'd1);

      // snoop kills reservation: idle snoop, same-cycle snoop, unrelated snoop
      run_op(AMO_OP_LR, 32'h200, 32'd0, 0, 0, 0, 0);
      snoop_idle(32'h200);
      run_op(AMO_OP_SC, 32'h200, 32'h11, 0, 0, 0, 0);
      chk("snoop_sc_rd", rd_value, 32'd1);
      run_op(AMO_OP_LR, 32'h204, 32'd0, 0, 0, 0, 0);
      run_op(AMO_OP_SC, 32'h204, 32'h22, 0, 0, 1, 32'h204);
      chk("snoop_same_sc_rd", rd_value, 32'd1);
      run_op(AMO_OP_LR, 32'h208, 32'd0, 0, 0, 0, 0);
      snoop_idle(32'h20C);
      run_op(AMO_OP_SC, 32'h208, 32'h33, 1, 2, 0, 0);
      chk("snoop_other_sc_rd", rd_value, 32'd0);

      // AMO store to the reserved word clears it
      run_op(AMO_OP_LR, 32'h500, 32'd0, 0, 0, 0, 0);
      run_op(AMO_OP_ADD, 32'h500, 32'd1, 0, 0, 0, 0);
      run_op(AMO_OP_SC, 32'h500, 32'h44, 0, 0, 0, 0);
      chk("amo_clr_sc_rd", rd_value, 32'd1);

      // AMOMAXU with 3 wait cycles on each access
      mem_wr(32'h300, 32'hFFFF_FFFF);
      run_op(AMO_OP_MAXU, 32'h300, 32'd1, 3, 3, 0, 0);
      chk("maxu_rd", rd_value, 32'hFFFF_FFFF);
      chk("maxu_mem", mem_rd(32'h300), 32'hFFFF_FFFF);
      chk("maxu_lat", got_lat, 32'd10);

      // misaligned and unknown-op aborts
      run_op(AMO_OP_SWAP, 32'h102, 32'h55, 0, 0, 0, 0);
      chk("mis_flag", {31'b0, misaligned}, 32'd1);
      chk("mis_rd", rd_value, 32'd0);
      chk("mis_lat", got_lat, 32'd1);
      run_op(5'b11111, 32'h100, 32'h55, 0, 0, 0, 0);
      chk("unk_mis", {31'b0, misaligned}, 32'd0);

      // reset in STORE with mem_valid high
      run_op(AMO_OP_LR, 32'h600, 32'd0, 0, 0, 0, 0);
      old = mem_rd(32'h700);
      @(negedge clk);
      start = 1; amo_op = AMO_OP_ADD; addr = 32'h700; rs2 = 32'd9;
      cur_op = AMO_OP_ADD; wait_l = 0; wait_s = 50;
      @(negedge clk);
      start = 0;
      for (int i = 0; i < 20 && !(mem_valid && mem_wstrb == 4'hF); i++) @(negedge clk);
      chk("reached_store", {31'b0, mem_valid}, 32'd1);
      #3 reset = 1;
      #1 chk("rst_async_valid", {31'b0, mem_valid}, 32'd0);
      acc_q.delete();
      m_rv = 0; last_rd = 0;
      repeat (2) @(negedge clk);
      reset = 0;
      chk("rst_partial_mem", mem_rd(32'h700), old);
      run_op(AMO_OP_SC, 32'h600, 32'h66, 0, 0, 0, 0);
      chk("rst_sc_rd", rd_value, 32'd1);

`ifdef AMO_RESV_TIMEOUT_EN
      run_op(AMO_OP_LR, 32'h800, 32'd0, 0, 0, 0, 0);
      repeat (7) @(negedge clk);
      run_op(AMO_OP_SC, 32'h800, 32'h77, 0, 0, 0, 0);
      chk("timeout_sc_rd", rd_value, 32'd1);
`endif

      // random traffic
      for (int n = 0; n < 200; n++) begin
         op = ops[$urandom_range(0, 11)];
         a  = bases[$urandom_range(0, 3)];
         if (op == AMO_OP_SC && $urandom_range(0, 1) == 1) a = lr_a;
         if ($urandom_range(0, 9) == 0) a = a + 32'($urandom_range(1, 3));
         if (op == AMO_OP_LR) lr_a = a;
         if ($urandom_range(0, 9) == 0) snoop_idle(bases[$urandom_range(0, 3)]);
         run_op(op, a, $urandom, $urandom_range(0, 3), $urandom_range(0, 3),
                ($urandom_range(0, 4) == 0), bases[$urandom_range(0, 3)]);
      end

      repeat (3) @(negedge clk);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/amo_sequencer.md
Name: amo_sequencer

Overview:
- Multicycle controller that runs RV32A atomics (AMO*.W, LR.W, SC.W) as a read-modify-write sequence on the shared memory port.
- Sits beside the main control FSM. The main FSM hands off on `start` and waits for `done`.
- Owns the LR/SC reservation register.
- Drives ALU operands and ALUOp = `ALU_OP_AMO`; the ALU decoder maps AMOop to the ALU function.

Parameters:
- XLEN, 32, data/address width.
- RESV_TIMEOUT, 1024, reservation lifetime in cycles; used only with the optional feature.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- start  in  1  one-cycle pulse; launch the atomic; sampled only in IDLE
- amo_op  in  `AMO_OP_WIDTH`  AMO opcode, latched on start
- addr  in  XLEN  rs1 value (effective address), latched on start
- rs2_data  in  XLEN  rs2 value, latched on start
- mem_valid  out  1  memory request valid
- mem_wstrb  out  4  4'b0000 = read, 4'b1111 = write
- mem_addr  out  XLEN  request address
- mem_wdata  out  XLEN  store data
- mem_rdata  in  XLEN  read data
- mem_ready  in  1  request accepted and complete this cycle
- alu_op  out  `ALU_OP_WIDTH`  constant `ALU_OP_AMO`
- alu_a  out  XLEN  loaded memory word
- alu_b  out  XLEN  latched rs2
- alu_result  in  XLEN  ALU output, combinational from alu_a/alu_b
- snoop_store  in  1  another store hit this word this cycle
- snoop_addr  in  XLEN  address of that store
- rd_value  out  XLEN  value to write back to rd
- done  out  1  one-cycle completion pulse
- misaligned  out  1  valid with done; addr[1:0] != 0

Behaviour:
- Reset values: state IDLE; all outputs 0 except alu_op = `ALU_OP_AMO`; reservation invalid.
- Handshake: mem_valid held high with addr/wstrb/wdata stable until mem_ready. Exactly one access completes per mem_ready.
- IDLE, start:
  - addr[1:0] != 0 → DONE with misaligned = 1, rd_value = 0, no memory access.
  - SC.W with reservation valid and resv_addr == addr[XLEN-1:2] → STORE, wdata = rs2.
  - SC.W otherwise → DONE, rd_value = 1, no memory access.
  - All other ops → LOAD.
- LOAD: read request.
  - On mem_ready: capture mem_rdata into `loaded`; rd_value = mem_rdata.
  - LR.W → set reservation to addr[XLEN-1:2], then DONE.
  - Other ops → COMPUTE.
- COMPUTE: one cycle.
  - Register store data: rs2 for AMOSWAP, alu_result for the rest.
  - Then STORE.
- STORE: write request.
  - On mem_ready → DONE.
  - For SC: rd_value = 0. For AMOs: rd_value stays `loaded`.
- DONE: done = 1 for one cycle, then IDLE. rd_value holds until the next start.
- Reservation invalidation:
  - Any SC clears it, whether it succeeds or fails.
  - Any completed AMO store to the reserved word clears it.
  - snoop_store with a matching snoop_addr[XLEN-1:2] clears it.
  - If a snoop clears the reservation in the same cycle an SC is decided in IDLE, the SC fails.
- start outside IDLE is ignored. mem_ready outside LOAD/STORE is ignored.
- Latency with zero-wait memory:
  - AMO: start→done = 4 cycles.
  - LR: 2 cycles.
  - SC success: 2 cycles.
  - SC fail / misaligned: 1 cycle.
- Reset mid-operation: immediate return to IDLE. mem_valid drops asynchronously; the partial access is abandoned; reservation cleared.
- Unknown amo_op: treated as a misaligned-style abort with misaligned = 0 and rd_value = 0.

Optional Feature:
- Macro: AMO_RESV_TIMEOUT_EN.
- Defined:
  - A clog2(RESV_TIMEOUT)-bit counter loads on LR.
  - Counts down each cycle while the reservation is valid.
  - At 0 the reservation is cleared. This guarantees forward progress for other harts.
- Undefined: no counter. The reservation persists until cleared by SC, a store, a snoop or reset.

Decomposition:
- Shared defines header: AMO_OP_* encodings, AMO_OP_WIDTH, ALU_OP_AMO; add the state encoding AMO_SEQ_S_* (IDLE, LOAD, COMPUTE, STORE, DONE).
- One sub-module, amo_reservation: holds valid/address, set/clear/snoop logic and the optional timeout counter; exposes resv_hit.

Test Plan:
- AMOADD.W at 0x100: mem holds 5, rs2 = 3, zero-wait → read, write 8, rd_value = 5, done 4 cycles after start.
- LR.W 0x200 then SC.W 0x200 (rs2 = 0xAA) → one write of 0xAA, rd_value = 0. A second SC.W 0x200 → no write, rd_value = 1.
- LR.W 0x200, snoop_store 0x200, SC.W 0x200 → SC fails, rd_value = 1, mem_valid never asserted.
- AMOMAXU.W: mem 0xFFFF_FFFF, rs2 = 1, mem_ready delayed 3 cycles on each access → written 0xFFFF_FFFF; mem_addr/wdata stable while waiting.
- AMOSWAP.W at 0x102 → misaligned = 1 with done one cycle after start, no mem_valid.
- Reset asserted in STORE with mem_valid high → mem_valid = 0 immediately. After release, SC.W to the prior LR address fails. With AMO_RESV_TIMEOUT_EN and RESV_TIMEOUT = 8: LR, wait 8 cycles, SC → fails.
